// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N-to-1 select stage.
package mux_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Select width never collapses to zero, even for a 2-input stage.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready skid buffer with a registered in_ready and a 1-cycle fill latency.
//
// state | meaning
// EMPTY | no entry held, in_ready=1
// ONE   | main register valid, in_ready=1
// TWO   | main and skid registers valid, in_ready=0
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_e      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;

    assign accept = in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        // Downstream stalled this cycle: park the beat behind main.
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= TWO;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-to-1 select with valid/ready handshake and sticky out-of-range error tracking.
// Build option MUX_N_REG_SKID_EN swaps the output register for a skid buffer with registered in_ready.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int               WIDTH       = 64,
    parameter int               NUM_IN      = 3,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    localparam int              SEL_W       = sel_w(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sel,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    input  logic                    err_clr
);

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    logic [WIDTH-1:0]     sel_val;
    logic                 sel_bad;
    logic                 accept;
    logic                 err_sel_q, err_sel_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        sel_val = DEFAULT_VAL;
        sel_bad = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(in_sel) == i) begin
                sel_val = in_data[i*WIDTH +: WIDTH];
                sel_bad = 1'b0;
            end
        end
    end

    assign accept = in_valid && in_ready;

    // A fresh illegal beat outranks a clear in the same cycle.
    always_comb begin
        err_sel_d = err_sel_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_sel_d = 1'b0;
            err_cnt_d = '0;
        end
        if (accept && sel_bad) begin
            err_sel_d = 1'b1;
            if (err_clr) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sel_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_sel_q <= err_sel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_sel = err_sel_q;
    assign err_cnt = err_cnt_q;

`ifdef MUX_N_REG_SKID_EN
    mux_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (sel_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );
`else
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (accept) begin
            data_d  = sel_val;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg (NUM_IN=3, WIDTH=64); adapts stall expectations to MUX_N_REG_SKID_EN.
module tb_mux_n_reg;

    localparam int WIDTH  = 64;
    localparam int NUM_IN = 3;
    localparam logic [63:0] CH0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] CH1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] CH2 = 64'h3333_3333_3333_3333;
`ifdef MUX_N_REG_SKID_EN
    localparam int STALL_N = 2;
`else
    localparam int STALL_N = 1;
`endif

    logic                    clk;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [1:0]              in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_sel;
    logic [7:0]              err_cnt;
    logic                    err_clr;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;

    mux_n_reg #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .DEFAULT_VAL ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    assign in_data = {CH2, CH1, CH0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] s);
        case (s)
            2'd0:    return CH0;
            2'd1:    return CH1;
            2'd2:    return CH2;
            default: return 64'h0;
        endcase
    endfunction

    // One cycle of stimulus: inputs change at negedge, accepted beats are queued, returns 1 after the edge.
    task automatic drive(input logic v, input logic [1:0] s, input logic ordy, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        if (!reset && v && in_ready) begin
            exp_q.push_back(model(s));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges with junk inputs applied, then check reset state.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_err_sel"}, 64'(err_sel), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops one expected beat for every delivery.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got %0h, expected no beat", out_data);
                end else begin
                    check("scoreboard", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int waits;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        out_ready = 1'b1;
        err_clr   = 1'b0;

        do_reset("rst");

        // Select sweep, back to back.
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        check("sweep_latency_valid", 64'(out_valid), 64'd1);
        check("sweep_ch0", out_data, CH0);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        check("sweep_ch1", out_data, CH1);
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        check("sweep_ch2", out_data, CH2);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check("sweep_drained", 64'(out_valid), 64'd0);

        // Illegal selects and error counter.
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        check("illegal_data", out_data, 64'd0);
        check("illegal_err_sel", 64'(err_sel), 64'd1);
        check("illegal_err_cnt", 64'(err_cnt), 64'd1);
        repeat (300) drive(1'b1, 2'd3, 1'b1, 1'b0);
        check("err_cnt_saturate", 64'(err_cnt), 64'd255);
        drive(1'b0, 2'd3, 1'b1, 1'b1);
        check("clr_err_sel", 64'(err_sel), 64'd0);
        check("clr_err_cnt", 64'(err_cnt), 64'd0);
        drive(1'b0, 2'd3, 1'b1, 1'b0);
        check("idle_illegal_sel", 64'(err_sel), 64'd0);
        check("idle_illegal_cnt", 64'(err_cnt), 64'd0);
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        check("err_cnt_two", 64'(err_cnt), 64'd2);
        drive(1'b1, 2'd3, 1'b1, 1'b1);
        check("clr_with_event_cnt", 64'(err_cnt), 64'd1);
        check("clr_with_event_sel", 64'(err_sel), 64'd1);
        drive(1'b1, 2'd1, 1'b1, 1'b1);
        check("legal_after_illegal", out_data, CH1);
        check("clr_after_legal", 64'(err_cnt), 64'd0);

        // Accept and deliver in the same cycle.
        n0 = n_acc;
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        check("sim_first", out_data, CH0);
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        check("sim_valid", 64'(out_valid), 64'd1);
        check("sim_second", out_data, CH2);
        check("sim_accepts", 64'(n_acc - n0), 64'd2);
        drive(1'b0, 2'd0, 1'b1, 1'b0);

        // Stall: out_ready low for 5 cycles with in_valid held high.
        n0 = n_acc;
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        check("stall_accepts", 64'(n_acc - n0), 64'(STALL_N));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_head", out_data, CH0);
        repeat (3) drive(1'b0, 2'd0, 1'b1, 1'b0);
        check("stall_drained_valid", 64'(out_valid), 64'd0);
        check("stall_drained_queue", 64'(exp_q.size()), 64'd0);

        // Reset with the buffer full of illegal beats.
        n0 = n_acc;
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        check("pre_reset_cnt", 64'(err_cnt), 64'(STALL_N));
        do_reset("midrst");
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        check("post_reset_data", out_data, CH2);
        drive(1'b0, 2'd0, 1'b1, 1'b0);

        // Pseudo-random handshake traffic, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), 1'b0);
        end
        waits = 0;
        while ((exp_q.size() != 0 || out_valid) && waits < 20) begin
            drive(1'b0, 2'd0, 1'b1, 1'b0);
            waits++;
        end
        check("random_drain_queue", 64'(exp_q.size()), 64'd0);
        check("random_drain_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
